// File: rtl/pong_enc_input.sv
// pong_enc_input: per-player input stage for pong_main.
// Brings a raw quadrature encoder (QA/QB) and a push-button into the pixel
// clock domain, debounces them, turns encoder rotation into a saturating
// paddle position, and republishes that position once per frame.
//
// Ports:
//   CLK, RST           pixel clock, synchronous active-high reset
//   ENC_QA, ENC_QB     raw encoder phases (asynchronous, idle high)
//   BTN                raw button, active-high (asynchronous)
//   FRAME_STB          one-cycle pulse at start of vertical blanking
//   PAD_Y              paddle top line, only changes on FRAME_STB
//   PAD_Y_LIVE         paddle top line, updates as soon as a step lands
//   STEP_UP / STEP_DN  one-cycle pulse when PAD_Y_LIVE decrements / increments
//   ENC_ERR            one-cycle pulse on an illegal (both-phase) transition
//   BTN_LVL            debounced button level
//   BTN_PRESS          one-cycle pulse on debounced button press
module pong_enc_input #(
    parameter int SCR_H   = 20,
    parameter int PAD_H   = 4,
    parameter int DEB_CYC = 4,
    parameter int QDIV    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENC_QA,
    input  logic        ENC_QB,
    input  logic        BTN,
    input  logic        FRAME_STB,
    output logic [10:0] PAD_Y,
    output logic [10:0] PAD_Y_LIVE,
    output logic        STEP_UP,
    output logic        STEP_DN,
    output logic        ENC_ERR,
    output logic        BTN_LVL,
    output logic        BTN_PRESS
);
    localparam logic [10:0]       Y_MAX    = 11'(SCR_H - PAD_H);
    localparam logic [10:0]       Y_MID    = 11'((SCR_H - PAD_H) / 2);
    localparam logic [7:0]        DEB_LAST = 8'(DEB_CYC - 1);
    localparam logic signed [4:0] ACC_TOP  = 5'(QDIV);
    // Idle values in {QA, QB, BTN} order: encoder pulled up, button released.
    localparam logic [2:0]        IDLE     = 3'b110;

    logic [2:0] raw, s1, s2, d;
    logic [7:0] cnt [3];

    assign raw = {ENC_QA, ENC_QB, BTN};

    // Two-flop synchroniser on every raw input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= IDLE;
            s2 <= IDLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce: the synchronised value must disagree with the stable value
    // for DEB_CYC consecutive clocks before it is accepted.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                d[i]   <= IDLE[i];
                cnt[i] <= '0;
            end else if (s2[i] == d[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
                d[i]   <= s2[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    // Map the Gray-coded phase pair onto a 0..3 position around the cycle,
    // so the modulo-4 difference directly names the transition type.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    logic [1:0]        prev, cur, delta;
    logic signed [4:0] acc, acc_inc, acc_dec;
    logic              fwd, rev, bad, btn_prev;

    assign cur     = d[2:1];
    assign delta   = phase(cur) - phase(prev);
    assign fwd     = (delta == 2'd1);
    assign rev     = (delta == 2'd3);
    assign bad     = (delta == 2'd2);
    assign acc_inc = acc + 5'sd1;
    assign acc_dec = acc - 5'sd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev       <= 2'b11;
            acc        <= '0;
            PAD_Y_LIVE <= Y_MID;
            PAD_Y      <= Y_MID;
            STEP_UP    <= 1'b0;
            STEP_DN    <= 1'b0;
            ENC_ERR    <= 1'b0;
            btn_prev   <= 1'b0;
            BTN_PRESS  <= 1'b0;
        end else begin
            prev    <= cur;
            STEP_UP <= 1'b0;
            STEP_DN <= 1'b0;
            ENC_ERR <= bad;
            if (bad) begin
                acc <= '0;
            end else if (fwd) begin
                if (acc_inc == ACC_TOP) begin
                    // acc clears even when the step is clamped away
                    acc <= '0;
                    if (PAD_Y_LIVE < Y_MAX) begin
                        PAD_Y_LIVE <= PAD_Y_LIVE + 11'd1;
                        STEP_DN    <= 1'b1;
                    end
                end else begin
                    acc <= acc_inc;
                end
            end else if (rev) begin
                if (acc_dec == -ACC_TOP) begin
                    acc <= '0;
                    if (PAD_Y_LIVE != '0) begin
                        PAD_Y_LIVE <= PAD_Y_LIVE - 11'd1;
                        STEP_UP    <= 1'b1;
                    end
                end else begin
                    acc <= acc_dec;
                end
            end
            // Nonblocking read of PAD_Y_LIVE publishes the pre-step value.
            if (FRAME_STB) PAD_Y <= PAD_Y_LIVE;
            btn_prev  <= d[0];
            BTN_PRESS <= d[0] & ~btn_prev;
        end
    end

    assign BTN_LVL = d[0];

endmodule
